// File: rtl/router_pkg.sv
// router_pkg: shared types and helpers for the router output arbiter.
//   arb_state_e : arbiter FSM states (IDLE / BUSY)
//   N_IN_DEF    : default number of requesting inputs
//   DW_DEF      : default flit data width
//   idx_w()     : width of an index into an n-entry vector
//   oh2idx()    : one-hot (up to 8 bits) to binary index
package router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int N_IN_DEF = 4;
  localparam int DW_DEF   = 32;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Returns the position of the set bit; 0 when no bit is set.
  function automatic int oh2idx(input logic [7:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority selector.
//   req_i : request vector (N bits)
//   ptr_i : index with highest priority this cycle
//   gnt_o : one-hot winner (all zero when no request)
//   vld_o : at least one request present
// Priority order is ptr, ptr+1, ... wrapping modulo N (N need not be a
// power of two). Also usable by the input-side VC allocator.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  int w_best_d;
  int w_best_i;
  int w_d;

  // The winner is the requester with the smallest forward distance from ptr.
  always_comb begin
    w_best_d = N;
    w_best_i = 0;
    w_d      = 0;
    for (int i = 0; i < N; i++) begin
      w_d = i - int'(ptr_i);
      if (w_d < 0) w_d = w_d + N;
      if (req_i[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_best_i = i;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = (w_best_d < N) && (w_best_i == i);
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/router_out_arbiter.sv
// router_out_arbiter: per-output wormhole arbiter with round-robin priority.
// Holds a grant from grant until the tail flit handshakes on the output.
//   clk, rst      : clock, synchronous active-high reset
//   req_i         : per-input packet request for this output
//   vld_i, last_i : per-input flit valid / tail
//   data_i        : per-input flit data, input i at [i*DW +: DW]
//   rdy_o         : per-input ready (only the granted input sees out_rdy_i)
//   out_vld_o, out_last_o, out_data_o : muxed output flit
//   out_rdy_i     : downstream ready
//   gnt_o         : registered one-hot grant
//   busy_o        : packet in flight
//   timeout_o     : one-cycle pulse on forced release
//   dbg_rr_ptr_o  : current round-robin pointer (debug)
// Handshake: a flit moves on a cycle where valid and ready are both high;
// valid must not depend on ready.
// Optional: define ROUTER_ARB_TIMEOUT_EN to add a stall counter that forces
// release after TIMEOUT_CYC cycles without a transfer.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       req_i,
  input  logic [N_IN-1:0]       vld_i,
  input  logic [N_IN-1:0]       last_i,
  input  logic [N_IN*DW-1:0]    data_i,
  output logic [N_IN-1:0]       rdy_o,
  output logic                  out_vld_o,
  output logic                  out_last_o,
  output logic [DW-1:0]         out_data_o,
  input  logic                  out_rdy_i,
  output logic [N_IN-1:0]       gnt_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [idx_w(N_IN)-1:0] dbg_rr_ptr_o
);

  localparam int IW = idx_w(N_IN);

  arb_state_e      r_state;
  arb_state_e      w_state_n;
  logic [N_IN-1:0] r_gnt;
  logic [N_IN-1:0] w_gnt_n;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_ptr_n;
  logic [IW-1:0]   w_gidx;
  logic [IW-1:0]   w_ptr_inc;
  logic [7:0]      w_gnt8;
  logic [N_IN-1:0] w_pick_gnt;
  logic            w_pick_vld;
  logic            w_xfer;
  logic            w_tail;
  logic            w_to_hit;

  rr_pick #(.N(N_IN), .IW(IW)) u_pick (
    .req_i (req_i),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_pick_gnt),
    .vld_o (w_pick_vld)
  );

  always_comb begin
    w_gnt8           = '0;
    w_gnt8[N_IN-1:0] = r_gnt;
  end

  assign w_gidx    = IW'(oh2idx(w_gnt8));
  // Explicit wrap so non-power-of-two N_IN works.
  assign w_ptr_inc = (w_gidx == IW'(N_IN - 1)) ? '0 : w_gidx + 1'b1;
  assign w_xfer    = out_vld_o & out_rdy_i;
  assign w_tail    = w_xfer & out_last_o;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_n;
      r_gnt    <= w_gnt_n;
      r_rr_ptr <= w_ptr_n;
    end
  end

  // Next-state logic. Request changes while BUSY are ignored.
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_ptr_n   = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_n = BUSY;
          w_gnt_n   = w_pick_gnt;
        end
      end
      BUSY: begin
        if (w_tail || w_to_hit) begin
          w_state_n = IDLE;
          w_gnt_n   = '0;
          w_ptr_n   = w_ptr_inc;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end

  // Output mux: zero-latency pass-through of the granted input.
  always_comb begin
    rdy_o      = '0;
    out_vld_o  = 1'b0;
    out_last_o = 1'b0;
    out_data_o = '0;
    if (r_state == BUSY) begin
      for (int i = 0; i < N_IN; i++) begin
        if (r_gnt[i]) begin
          out_vld_o  = vld_i[i];
          out_last_o = last_i[i];
          out_data_o = data_i[i*DW +: DW];
          rdy_o[i]   = out_rdy_i;
        end
      end
    end
  end

  assign gnt_o        = r_gnt;
  assign busy_o       = (r_state == BUSY);
  assign dbg_rr_ptr_o = r_rr_ptr;

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_stall;
  logic          r_timeout;

  assign w_to_hit = (r_state == BUSY) && (r_stall == CW'(TIMEOUT_CYC));

  // Held at zero in IDLE so it starts from zero on entering BUSY.
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE) || w_xfer) begin
      r_stall <= '0;
    end else if (!w_to_hit) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // A tail on the hit cycle is a normal release, not a timeout.
  always_ff @(posedge clk) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_to_hit & ~w_tail;
  end

  assign timeout_o = r_timeout;
`else
  assign w_to_hit  = 1'b0;
  // Always 0 for any legal TIMEOUT_CYC; referencing it keeps the parameter used.
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

endmodule
